// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding, command bytes and default timing for the PS/2 host path
package ps2_pkg;
  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SEND,
    ACK,
    WAIT_IDLE,
    DONE,
    ERROR
  } ps2_state_e;
  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ECHO = 8'hEE;
  localparam logic [7:0] PS2_CMD_RESET = 8'hFF;
  localparam int PS2_INHIBIT_CYCLES = 10000;
  localparam int PS2_DATA_SETUP_CYCLES = 100;
  localparam int PS2_TIMEOUT_CYCLES = 2000000;
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction
endpackage

// File: rtl/ps2_edge_sync.sv
// ps2_edge_sync: 2-flop synchronisers for PS/2 clock and data plus clock falling-edge detect
module ps2_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_sync_o,
  output logic data_sync_o,
  output logic clk_fe_o
);
  logic [1:0] clk_sq, data_sq;
  logic clk_prev_q;
  // idle bus is high, so reset to 1 to avoid a spurious edge after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sq <= 2'b11;
      data_sq <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sq <= {clk_sq[0], ps2_clk_i};
      data_sq <= {data_sq[0], ps2_data_i};
      clk_prev_q <= clk_sq[1];
    end
  end
  assign clk_sync_o = clk_sq[1];
  assign data_sync_o = data_sq[1];
  assign clk_fe_o = clk_prev_q & ~clk_sq[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte from host to a PS/2 device over open-drain clock/data
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int DATA_SETUP_CYCLES = PS2_DATA_SETUP_CYCLES,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low
);
  localparam int IW = $clog2(INHIBIT_CYCLES) + 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [IW-1:0] SETUP_AT = IW'(INHIBIT_CYCLES - DATA_SETUP_CYCLES);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
  ps2_state_e state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [3:0] bit_q, bit_d;
  logic [7:0] byte_q, byte_d;
  logic par_q, par_d, clk_dl_q, clk_dl_d, data_dl_q, data_dl_d;
  logic clk_s, data_s, fe;
  ps2_edge_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk_i  (ps2_clk_in),
    .ps2_data_i (ps2_data_in),
    .clk_sync_o (clk_s),
    .data_sync_o(data_s),
    .clk_fe_o   (fe)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wd_q <= '0;
      bit_q <= '0;
      byte_q <= '0;
      par_q <= 1'b0;
      clk_dl_q <= 1'b0;
      data_dl_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wd_q <= wd_d;
      bit_q <= bit_d;
      byte_q <= byte_d;
      par_q <= par_d;
      clk_dl_q <= clk_dl_d;
      data_dl_q <= data_dl_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wd_d = wd_q;
    bit_d = bit_q;
    byte_d = byte_q;
    par_d = par_q;
    data_dl_d = data_dl_q;
    case (state_q)
      IDLE: if (tx_valid) begin
        byte_d = tx_data;
        par_d = odd_parity(tx_data);
        cnt_d = '0;
        data_dl_d = (DATA_SETUP_CYCLES >= INHIBIT_CYCLES);
        state_d = INHIBIT;
      end
      INHIBIT: if (cnt_q == INH_LAST) begin
        state_d = SEND;
        bit_d = '0;
        wd_d = '0;
        data_dl_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        data_dl_d = cnt_d >= SETUP_AT;
      end
      // the line only changes on device falling edges; the device samples on rising ones
      SEND: if (fe) begin
        data_dl_d = bit_q < 4'd8 ? ~byte_q[bit_q[2:0]] : bit_q == 4'd8 ? ~par_q : 1'b0;
        bit_d = bit_q == 4'd9 ? 4'd0 : bit_q + 4'd1;
        state_d = bit_q == 4'd9 ? ACK : SEND;
      end
      ACK: if (fe) state_d = data_s ? ERROR : WAIT_IDLE;
      WAIT_IDLE: if (clk_s && data_s) state_d = DONE;
      DONE, ERROR: begin
        state_d = IDLE;
        data_dl_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (state_q == SEND || state_q == ACK || state_q == WAIT_IDLE) begin
      wd_d = fe ? '0 : wd_q + 1'b1;
      if (!fe && wd_q == WD_LAST && state_d == state_q) begin
        state_d = ERROR;
        data_dl_d = 1'b0;
      end
    end
    clk_dl_d = state_d == INHIBIT;
  end
  assign tx_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign tx_done = state_q == DONE;
  assign tx_error = state_q == ERROR;
  assign ps2_clk_drive_low = clk_dl_q;
  assign ps2_data_drive_low = data_dl_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: device BFM on open-drain lines with a frame-level reference model
module tb_ps2_host_tx;
  import ps2_pkg::*;
  localparam int INH = 20, SET = 4, TO = 500;
  logic clk = 0, rst_n = 0, tx_valid = 0;
  logic [7:0] tx_data = 0;
  logic tx_ready, tx_done, tx_error, busy, clk_dl, data_dl;
  logic dev_clk_low = 0, dev_data_low = 0;
  logic ps2_clk_line, ps2_data_line;
  int checks = 0, errors = 0, cyc = 0, done_cnt = 0, err_cnt = 0, last_fall = 0, last_err = 0;
  assign ps2_clk_line = ~(clk_dl | dev_clk_low);
  assign ps2_data_line = ~(data_dl | dev_data_low);
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .DATA_SETUP_CYCLES(SET), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_error(tx_error), .busy(busy),
    .ps2_clk_in(ps2_clk_line), .ps2_data_in(ps2_data_line),
    .ps2_clk_drive_low(clk_dl), .ps2_data_drive_low(data_dl)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_error) begin
      err_cnt++;
      last_err = cyc;
    end
  end
  initial begin
    #3000000;
    $display("FAIL global_timeout sim did not finish");
    $fatal(1);
  end
  // device clocks nbits bits (40-cycle period), sampling data at each rising edge;
  // ack_mode 1 adds an 11th clock with data pulled low, 2 adds it with data left high
  task automatic bfm(input int nbits, input int ack_mode, output logic [9:0] samp);
    samp = '0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      dev_clk_low = 1;
      last_fall = cyc;
      repeat (20) @(negedge clk);
      dev_clk_low = 0;
      samp[i] = ps2_data_line;
      repeat (20) @(negedge clk);
    end
    if (ack_mode != 0) begin
      if (ack_mode == 1) dev_data_low = 1;
      repeat (5) @(negedge clk);
      dev_clk_low = 1;
      last_fall = cyc;
      repeat (20) @(negedge clk);
      dev_clk_low = 0;
      repeat (5) @(negedge clk);
      dev_data_low = 0;
    end
  endtask
  task automatic start_tx(input logic [7:0] b, input string name);
    int n, dn;
    bit late_ok;
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL %s ready got %b want 1", name, tx_ready); end
    tx_valid = 1;
    tx_data = b;
    @(negedge clk);
    tx_valid = 0;
    tx_data = 8'($urandom);
    n = 0; dn = 0; late_ok = 1;
    while (clk_dl === 1'b1 && n < 1000) begin
      if (data_dl === 1'b1) begin
        dn++;
        if (n < INH - SET) late_ok = 0;
      end
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != INH) begin errors++; $display("FAIL %s inhibit_len got %0d want %0d", name, n, INH); end
    checks++;
    if (dn != SET || !late_ok) begin errors++; $display("FAIL %s setup_len got %0d late_ok %0d want %0d 1", name, dn, late_ok, SET); end
    checks++;
    if (data_dl !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL %s start_bit got dl %b busy %b want 1 1", name, data_dl, busy); end
  endtask
  task automatic run_frame(input logic [7:0] b, input int ack_mode, input bit inject, input string name);
    logic [9:0] samp, exp;
    int d0, e0, n;
    d0 = done_cnt; e0 = err_cnt;
    exp = {1'b1, ($countones(b) % 2 == 0), b};
    start_tx(b, name);
    if (inject) begin
      tx_valid = 1;
      tx_data = 8'h55;
      @(negedge clk);
      tx_valid = 0;
    end
    bfm(10, ack_mode, samp);
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    checks++;
    if (samp !== exp) begin errors++; $display("FAIL %s frame got %b want %b", name, samp, exp); end
    checks++;
    if (ack_mode == 1 ? (done_cnt != d0 + 1 || err_cnt != e0) : (err_cnt != e0 + 1 || done_cnt != d0)) begin
      errors++;
      $display("FAIL %s pulses got done %0d err %0d want done %0d err %0d", name, done_cnt - d0, err_cnt - e0,
               ack_mode == 1 ? 1 : 0, ack_mode == 1 ? 0 : 1);
    end
    checks++;
    if (tx_ready !== 1'b1 || clk_dl !== 1'b0 || data_dl !== 1'b0) begin
      errors++;
      $display("FAIL %s idle got ready %b cdl %b ddl %b want 1 0 0", name, tx_ready, clk_dl, data_dl);
    end
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_ready, busy, tx_done, tx_error, clk_dl, data_dl} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_hold got %b want 100000", {tx_ready, busy, tx_done, tx_error, clk_dl, data_dl});
    end
    rst_n = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_ready, busy, tx_done, tx_error, clk_dl, data_dl} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_release got %b want 100000", {tx_ready, busy, tx_done, tx_error, clk_dl, data_dl});
    end
  endtask
  task automatic test_commands;
    run_frame(PS2_CMD_SET_LED, 1, 0, "set_led");
    run_frame(8'h07, 1, 0, "parity_07");
    run_frame(8'h00, 1, 0, "parity_00");
    repeat (4) run_frame(8'($urandom), 1, 0, "random");
  endtask
  task automatic test_nack;
    run_frame(8'($urandom), 2, 0, "nack");
  endtask
  task automatic test_timeout;
    logic [9:0] samp;
    logic [7:0] b;
    int d0, e0, n;
    b = 8'($urandom);
    d0 = done_cnt; e0 = err_cnt;
    start_tx(b, "timeout");
    bfm(4, 0, samp);
    n = 0;
    while (err_cnt == e0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    // 2 synchroniser flops, then the watchdog starts from zero one cycle after the edge
    checks++;
    if (err_cnt != e0 + 1 || last_err - last_fall != TO + 3) begin
      errors++;
      $display("FAIL timeout delay got %0d errs %0d want %0d errs 1", last_err - last_fall, err_cnt - e0, TO + 3);
    end
    checks++;
    if (samp[3:0] !== b[3:0] || done_cnt != d0 || clk_dl !== 1'b0 || data_dl !== 1'b0) begin
      errors++;
      $display("FAIL timeout state got bits %b done %0d cdl %b ddl %b want %b 0 0 0", samp[3:0], done_cnt - d0, clk_dl, data_dl, b[3:0]);
    end
  endtask
  task automatic test_busy_ignore;
    int nb;
    run_frame(8'($urandom), 1, 1, "busy_ignore");
    nb = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy !== 1'b0 || clk_dl !== 1'b0) nb++;
    end
    checks++;
    if (nb != 0) begin errors++; $display("FAIL busy_ignore second_frame got %0d busy cycles want 0", nb); end
  endtask
  task automatic test_reset_mid;
    logic [9:0] samp;
    int d0, e0;
    start_tx(8'($urandom) & 8'hEF, "reset_mid");
    bfm(5, 0, samp);
    checks++;
    if (data_dl !== 1'b1) begin errors++; $display("FAIL reset_mid bit4 got %b want 1", data_dl); end
    rst_n = 0;
    #1;
    checks++;
    if (clk_dl !== 1'b0 || data_dl !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid release got cdl %b ddl %b want 0 0", clk_dl, data_dl);
    end
    @(negedge clk);
    rst_n = 1;
    d0 = done_cnt; e0 = err_cnt;
    repeat (50) @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1 || done_cnt != d0 || err_cnt != e0) begin
      errors++;
      $display("FAIL reset_mid after got ready %b done %0d err %0d want 1 0 0", tx_ready, done_cnt - d0, err_cnt - e0);
    end
  endtask
  initial begin
    test_reset();
    test_commands();
    test_nack();
    test_timeout();
    test_busy_ignore();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard through open-drain clock and data lines. It is the companion of the existing PS/2 receive path, which decodes direction keys for the snake game. While a frame is in flight, the block flags the receiver so the receiver ignores the bus.

Parameters:
INHIBIT_CYCLES, 10000, cycles the host holds PS2 clock low before the request (100 us at 100 MHz)
DATA_SETUP_CYCLES, 100, final cycles of the inhibit window during which data is also driven low
TIMEOUT_CYCLES, 2000000, maximum cycles between device clock falling edges, and the maximum wait for bus idle (20 ms)

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
tx_valid  in  1  request to send tx_data
tx_data  in  8  command byte
tx_ready  out  1  high only in IDLE; a byte is accepted when tx_valid && tx_ready
tx_done  out  1  one-cycle pulse when the frame completes and the device has acknowledged
tx_error  out  1  one-cycle pulse on timeout or missing ACK
busy  out  1  high whenever state != IDLE; drives the receiver's ignore input
ps2_clk_in  in  1  raw PS2_CLK pin level
ps2_data_in  in  1  raw PS2_DATA pin level
ps2_clk_drive_low  out  1  1 = pull PS2_CLK low; 0 = release (pin is high-Z)
ps2_data_drive_low  out  1  1 = pull PS2_DATA low; 0 = release

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: state IDLE, tx_ready=1, busy=0, tx_done=0, tx_error=0, both drive_low outputs 0.
- Asserting rst_n low mid-frame releases both lines immediately. No pulse is emitted.
- Input sync: ps2_clk_in and ps2_data_in each pass through 2 flip-flops. A falling edge (fe) is registered previous=1, current=0 on the synchronised clock.
- Accept: on tx_valid && tx_ready, latch tx_data and compute parity = ~^tx_data (odd parity). tx_valid is ignored in all other states.
- IDLE -> INHIBIT on accept.
- INHIBIT: clk_drive_low=1; counter runs 0..INHIBIT_CYCLES-1.
  - data_drive_low=1 once count >= INHIBIT_CYCLES-DATA_SETUP_CYCLES. This is the start bit.
  - At the terminal count go to SEND.
- SEND: clk_drive_low=0; data stays low (start bit). bitcnt (4 bits) starts at 0. On each fe:
  - bitcnt 0..7: drive data_drive_low = ~byte[bitcnt], LSB first.
  - bitcnt 8: drive ~parity.
  - bitcnt 9: data_drive_low=0 (stop bit, line released).
  - bitcnt increments on each fe. After the fe with bitcnt=9, go to ACK.
- ACK: on the next fe, sample synced data.
  - data=0: ack_ok; go to WAIT_IDLE.
  - data=1: go to ERROR.
- WAIT_IDLE: when synced clk=1 and data=1, go to DONE.
- DONE: pulse tx_done for 1 cycle, then IDLE.
- ERROR: release both lines, pulse tx_error for 1 cycle, then IDLE.
- Timeout: a watchdog counter is cleared on entry to SEND and on every fe. It counts in SEND, ACK and WAIT_IDLE. Reaching TIMEOUT_CYCLES forces ERROR.
- Data is changed only on device falling edges (device samples on rising edges). No other transitions on the data output.
- Latency (cycles from accept to first SEND cycle): INHIBIT_CYCLES+1.
- Widths: the inhibit and watchdog counters are sized with $clog2 of their parameter plus 1. Neither counter wraps; each saturates at its terminal condition.

Decomposition:
- Shared package ps2_pkg:
  - State encoding: IDLE, INHIBIT, SEND, ACK, WAIT_IDLE, DONE, ERROR.
  - Command constants: PS2_CMD_SET_LED=8'hED, PS2_CMD_ECHO=8'hEE, PS2_CMD_RESET=8'hFF.
  - Default timing constants.
- One natural sub-module: ps2_edge_sync. It contains the 2-FF synchronisers for both lines plus clock falling-edge detection. The existing receiver can reuse it.

Test Plan:
All directed tests use INHIBIT_CYCLES=20, DATA_SETUP_CYCLES=4, TIMEOUT_CYCLES=500, and a device BFM clocking at 40-cycle period.
- Send 0xED, BFM ACKs.
  - Required: clk held low for exactly 20 cycles; data low during the last 4 of them.
  - BFM samples bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done pulses once, tx_error stays 0, tx_ready returns to 1.
- Send 0x07 -> sampled parity 0. Send 0x00 -> sampled parity 1. Both frames end in tx_done.
- BFM leaves data high in the ACK slot -> tx_error pulse, no tx_done, both drive_low=0.
- BFM stops clocking after bit 3 -> tx_error exactly 500 cycles after the last fe, lines released.
- tx_valid pulsed with 0x55 while busy=1 -> byte ignored; only the first frame appears on the wire.
- rst_n low mid-SEND (bitcnt=5) -> both drive_low outputs 0 in the same cycle. After release: tx_ready=1 and no pulses.
